// File: rtl/keypad_pkg.sv
// Shared constants for the hex keypad reader: FSM encoding, default timing
// parameters and the {row,col} key codes used by display/CPU test programs.
package keypad_pkg;

  localparam int SCAN_DIV_DEFAULT    = 50000;
  localparam int DEB_SAMPLES_DEFAULT = 4;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_RELEASE  = 2'd2;

  // Key codes are {row[1:0], col[1:0]}
  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  function automatic logic [3:0] key_code_of(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction

  // Lowest-numbered low (pressed) row wins when several rows read low
  function automatic logic [1:0] first_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_reader_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, tick-sampled agreement counter
// and a one-clock pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEB_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = $clog2(DEB_SAMPLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Flip the debounced level only after DEB_SAMPLES consecutive disagreeing ticks
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    if (tick_i) begin
      if (sync2_q != level_q) begin
        if (cnt_q == CW'(DEB_SAMPLES - 1)) begin
          level_d = sync2_q;
          cnt_d   = '0;
          rise_d  = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/keypad_reader.sv
// 4x4 hex keypad scanner with debounce, 16-bit digit accumulator and an
// Enter-triggered valid/ready hand-off to the CPU input port.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_SCAN     | rotating the low column, looking for any low row
// ST_DEBOUNCE | column frozen, counting ticks the latched row stays low
// ST_RELEASE  | key accepted, column frozen until all rows high long enough
module keypad_reader import keypad_pkg::*; #(
  parameter int SCAN_DIV    = SCAN_DIV_DEFAULT,
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        btn_enter,
  output logic [3:0]  col,
  output logic [15:0] entry,
  output logic [3:0]  key_code,
  output logic        key_strobe,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_SAMPLES + 1);

  logic [TW-1:0] div_q, div_d;
  logic          tick;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [1:0]    state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    col_q, col_d;
  logic          accept;
  logic [3:0]    code;
  logic [15:0]   entry_shift;
  logic [15:0]   entry_q, entry_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_strobe_q, key_strobe_d;
  logic [15:0]   data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          enter_rise;

  assign tick  = (div_q == TW'(SCAN_DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  // Free-running scan divider and row synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      div_q    <= div_d;
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_enter_deb (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick),
    .btn_i  (btn_enter),
    .rise_o (enter_rise)
  );

  // Scan FSM: all decisions are taken only on scan ticks
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (row_s2_q != 4'hF) begin
            row_idx_d = first_low_row(row_s2_q);
            cnt_d     = CW'(1);
            state_d   = ST_DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (!row_s2_q[row_idx_q]) begin
            if (cnt_q == CW'(DEB_SAMPLES - 1)) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = ST_RELEASE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_SCAN;
          end
        end
        ST_RELEASE: begin
          if (row_s2_q == 4'hF) begin
            if (cnt_q == CW'(DEB_SAMPLES - 1)) begin
              cnt_d     = '0;
              state_d   = ST_SCAN;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  assign code        = key_code_of(row_idx_q, col_idx_q);
  assign entry_shift = accept ? {entry_q[11:0], code} : entry_q;
  assign col_d       = ~(4'b0001 << col_idx_d);

  // Digit accumulator and CPU hand-off; a same-cycle Enter captures the new digit
  always_comb begin
    key_code_d   = accept ? code : key_code_q;
    key_strobe_d = accept;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q & ~data_ready;
    entry_d      = entry_shift;
    if (enter_rise) begin
      data_out_d   = entry_shift;
      data_valid_d = 1'b1;
      entry_d      = '0;
    end
  end

  // FSM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SCAN;
      col_idx_q    <= 2'd0;
      row_idx_q    <= 2'd0;
      cnt_q        <= '0;
      col_q        <= 4'b1110;
      entry_q      <= '0;
      key_code_q   <= '0;
      key_strobe_q <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_idx_q    <= col_idx_d;
      row_idx_q    <= row_idx_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      entry_q      <= entry_d;
      key_code_q   <= key_code_d;
      key_strobe_q <= key_strobe_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign col        = col_q;
  assign entry      = entry_q;
  assign key_code   = key_code_q;
  assign key_strobe = key_strobe_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_keypad_reader.sv
// Directed bench for keypad_reader with a behavioural 4x4 key matrix model.
module tb_keypad_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic        btn_enter;
  logic [3:0]  col;
  logic [15:0] entry;
  logic [3:0]  key_code;
  logic        key_strobe;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;

  logic [15:0] pressed;
  logic        force_en;
  logic [3:0]  force_row;
  logic [3:0]  model_row;

  int vectors     = 0;
  int miscompares = 0;
  int strobes     = 0;
  int base;

  always #5 clk = ~clk;

  keypad_reader #(.SCAN_DIV(4), .DEB_SAMPLES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .btn_enter  (btn_enter),
    .col        (col),
    .entry      (entry),
    .key_code   (key_code),
    .key_strobe (key_strobe),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready)
  );

  // Matrix model: a pressed key pulls its row low while its column is driven low
  always_comb begin
    model_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) model_row[r] = 1'b0;
  end
  assign row = force_en ? force_row : model_row;

  always @(negedge clk) if (key_strobe) strobes++;

  task automatic wait_ticks(input int n);
    repeat (n*4) @(negedge clk);
  endtask

  task automatic press_key(input logic [3:0] k);
    pressed = 16'd1 << k;
    wait_ticks(12);
    pressed = '0;
    wait_ticks(6);
  endtask

  task automatic press_enter();
    btn_enter = 1'b1;
    wait_ticks(6);
    btn_enter = 1'b0;
    wait_ticks(6);
  endtask

  task automatic consume();
    @(negedge clk); data_ready = 1'b1;
    @(negedge clk); data_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++; if (col !== 4'b1110) begin miscompares++; $display("FAIL reset_col got %b want 1110", col); end
    vectors++; if (entry !== 16'h0) begin miscompares++; $display("FAIL reset_entry got %h want 0000", entry); end
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", data_valid); end
    vectors++; if (key_code !== 4'h0 || key_strobe !== 1'b0 || data_out !== 16'h0) begin
      miscompares++; $display("FAIL reset_misc got code=%h strobe=%b dout=%h want 0/0/0000", key_code, key_strobe, data_out);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    base = strobes;
    press_key(4'h6);
    vectors++; if (strobes - base !== 1) begin miscompares++; $display("FAIL clean_strobes got %0d want 1", strobes - base); end
    vectors++; if (key_code !== 4'h6) begin miscompares++; $display("FAIL clean_code got %h want 6", key_code); end
    vectors++; if (entry !== 16'h0006) begin miscompares++; $display("FAIL clean_entry got %h want 0006", entry); end
  endtask

  task automatic test_bounce();
    base = strobes;
    force_en = 1'b1;
    force_row = 4'b1110; wait_ticks(1);
    force_row = 4'b1111; wait_ticks(1);
    force_row = 4'b1110; wait_ticks(1);
    force_row = 4'b1111; wait_ticks(6);
    force_en = 1'b0;
    vectors++; if (strobes - base !== 0) begin miscompares++; $display("FAIL bounce_strobes got %0d want 0", strobes - base); end
    vectors++; if (entry !== 16'h0006) begin miscompares++; $display("FAIL bounce_entry got %h want 0006", entry); end
    base = strobes;
    press_key(4'hA);
    vectors++; if (strobes - base !== 1) begin miscompares++; $display("FAIL stable_strobes got %0d want 1", strobes - base); end
    vectors++; if (key_code !== 4'hA || entry !== 16'h006A) begin
      miscompares++; $display("FAIL stable_key got code=%h entry=%h want A/006A", key_code, entry);
    end
  endtask

  task automatic test_accumulation();
    for (int k = 1; k <= 5; k++) press_key(4'(k));
    vectors++; if (entry !== 16'h2345) begin miscompares++; $display("FAIL accum_entry got %h want 2345", entry); end
    press_enter();
    vectors++; if (data_out !== 16'h2345) begin miscompares++; $display("FAIL enter_dout got %h want 2345", data_out); end
    vectors++; if (data_valid !== 1'b1) begin miscompares++; $display("FAIL enter_valid got %b want 1", data_valid); end
    vectors++; if (entry !== 16'h0) begin miscompares++; $display("FAIL enter_entry got %h want 0000", entry); end
    consume();
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL consume_valid got %b want 0", data_valid); end
    consume();
    vectors++; if (data_valid !== 1'b0 || data_out !== 16'h2345) begin
      miscompares++; $display("FAIL idle_ready got valid=%b dout=%h want 0/2345", data_valid, data_out);
    end
  endtask

  task automatic test_overwrite();
    logic seen;
    press_key(4'hA);
    press_key(4'hB);
    press_enter();
    vectors++; if (data_out !== 16'h00AB || data_valid !== 1'b1) begin
      miscompares++; $display("FAIL ovw_first got dout=%h valid=%b want 00AB/1", data_out, data_valid);
    end
    press_key(4'hC);
    press_enter();
    vectors++; if (data_out !== 16'h000C || data_valid !== 1'b1) begin
      miscompares++; $display("FAIL ovw_second got dout=%h valid=%b want 000C/1", data_out, data_valid);
    end
    press_key(4'hD);
    seen = 1'b0;
    btn_enter = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (dut.enter_rise) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL coincide_timeout got no enter edge want edge within 200 clocks");
    end else begin
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      if (data_valid !== 1'b1 || data_out !== 16'h000D) begin
        miscompares++; $display("FAIL coincide got valid=%b dout=%h want 1/000D", data_valid, data_out);
      end
    end
    wait_ticks(6);
    btn_enter = 1'b0;
    wait_ticks(6);
    vectors++; if (data_valid !== 1'b1 || entry !== 16'h0) begin
      miscompares++; $display("FAIL coincide_after got valid=%b entry=%h want 1/0000", data_valid, entry);
    end
    consume();
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL ovw_consume got %b want 0", data_valid); end
  endtask

  task automatic test_two_rows();
    base = strobes;
    pressed = (16'd1 << 3) | (16'd1 << 11);
    wait_ticks(12);
    vectors++; if (strobes - base !== 1 || key_code !== 4'h3) begin
      miscompares++; $display("FAIL two_rows got strobes=%0d code=%h want 1/3", strobes - base, key_code);
    end
    pressed = 16'd1 << 11;
    wait_ticks(10);
    vectors++; if (strobes - base !== 1) begin miscompares++; $display("FAIL held_second got %0d want 1", strobes - base); end
    pressed = '0;
    wait_ticks(6);
    vectors++; if (entry !== 16'h0003) begin miscompares++; $display("FAIL two_rows_entry got %h want 0003", entry); end
    press_key(4'h7);
    vectors++; if (strobes - base !== 2 || entry !== 16'h0037) begin
      miscompares++; $display("FAIL rescan got strobes=%0d entry=%h want 2/0037", strobes - base, entry);
    end
  endtask

  task automatic test_reset_mid();
    press_enter();
    press_key(4'h8);
    vectors++; if (data_valid !== 1'b1 || entry !== 16'h0008) begin
      miscompares++; $display("FAIL pre_reset got valid=%b entry=%h want 1/0008", data_valid, entry);
    end
    base = strobes;
    force_en = 1'b1;
    force_row = 4'b1101;
    wait_ticks(2);
    #2 rst = 1'b1;
    #1;
    vectors++; if (col !== 4'b1110 || entry !== 16'h0 || data_valid !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset got col=%b entry=%h valid=%b want 1110/0000/0", col, entry, data_valid);
    end
    vectors++; if (key_code !== 4'h0 || data_out !== 16'h0) begin
      miscompares++; $display("FAIL mid_reset_regs got code=%h dout=%h want 0/0000", key_code, data_out);
    end
    force_row = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(8);
    force_en = 1'b0;
    vectors++; if (strobes - base !== 0 || entry !== 16'h0) begin
      miscompares++; $display("FAIL discard got strobes=%0d entry=%h want 0/0000", strobes - base, entry);
    end
  endtask

  initial begin
    pressed    = '0;
    force_en   = 1'b0;
    force_row  = 4'hF;
    btn_enter  = 1'b0;
    data_ready = 1'b0;
    test_reset();
    wait_ticks(2);
    test_clean_press();
    test_bounce();
    test_accumulation();
    test_overwrite();
    test_two_rows();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish before 2000000");
    $fatal(1);
  end

endmodule

// File: doc/keypad_reader.md
# keypad_reader

Input-side counterpart to the board's seven-segment display path. It scans a 4x4 hex matrix keypad and debounces both the keypad and a separate Enter push-button. Accepted hex digits are accumulated into a 16-bit entry value, and on Enter that value is handed to the CPU's input port through a valid/ready handshake. `entry` is exported so the display block can echo digits as they are typed.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clocks per scan tick (one column slot).
- `DEB_SAMPLES`, default 4: consecutive agreeing tick samples required to accept a press or a release.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `row`, in, 4: keypad rows; active-low, externally pulled up; asynchronous.
- `btn_enter`, in, 1: Enter button; active-high; asynchronous.
- `col`, out, 4: keypad column drive; one column low at a time.
- `entry`, out, 16: digits typed since the last Enter; newest digit in `[3:0]`.
- `key_code`, out, 4: code of the last accepted key.
- `key_strobe`, out, 1: one-clock pulse on key acceptance.
- `data_out`, out, 16: value latched on Enter.
- `data_valid`, out, 1: `data_out` is pending for the CPU.
- `data_ready`, in, 1: CPU consumes `data_out`.

## Operation
- **Tick:** a free-running counter runs 0..`SCAN_DIV`-1; `tick` is asserted for the one clock where the counter equals `SCAN_DIV`-1.
- **Synchronisers:** `row` and `btn_enter` each pass through a 2-FF synchroniser. All sampling happens only on `tick`.
- **Column drive:** `col = ~(4'b0001 << col_idx)`. `col_idx` advances mod 4 on `tick`, only in SCAN.
- **FSM states:** SCAN, DEBOUNCE, RELEASE.
  - **SCAN:** on `tick`, if any synchronised row is low, latch `row_idx` (lowest-numbered low row wins) and `col_idx`, set count=1, go to DEBOUNCE. Otherwise advance `col_idx`.
  - **DEBOUNCE:** the column is frozen. On `tick`, if the latched row is still low, increment count. When count reaches `DEB_SAMPLES`, accept the key and go to RELEASE. If the latched row reads high, go to SCAN with count cleared (no acceptance).
  - **RELEASE:** the column stays frozen. Count consecutive `tick` samples where all rows are high. On `DEB_SAMPLES` such samples, go to SCAN and advance `col_idx`. Any low sample resets the count.
- **Key code:** `key_code = {row_idx[1:0], col_idx[1:0]}`, giving values 0..F.
- **On acceptance:**
  - `entry <= {entry[11:0], code}`; the oldest digit is discarded with no saturation.
  - `key_code <= code`.
  - `key_strobe` pulses for one clock.
- **Enter:** `btn_enter` is debounced by its own unit (`DEB_SAMPLES` agreeing ticks). On the debounced rising edge:
  - `data_out <= entry`, `data_valid <= 1`, `entry <= 0`.
  - If `data_valid` was already 1, `data_out` is overwritten and `data_valid` stays 1.
- **Handshake:**
  - `data_valid && data_ready` on a clock edge clears `data_valid` at the next edge.
  - `data_ready` while `data_valid` is low is ignored.
  - If an Enter edge and a consume occur in the same cycle, the Enter wins: the new data is latched and `data_valid` stays 1.
- **Key acceptance and Enter in the same cycle:** the Enter latch takes the `entry` value after the shift-in (the new digit is included), then `entry` is cleared.
- **Reset:** `col`=1110, `col_idx`=0, state SCAN, all counters 0, `entry`=0, `key_code`=0, `key_strobe`=0, `data_out`=0, `data_valid`=0, debounced Enter=0. Reset mid-debounce discards the pending key.

## Timing
- Keypad acceptance latency is `DEB_SAMPLES` ticks from the first low sample, plus 2–3 clocks of synchroniser delay. `key_strobe` and the `entry` update occur on the clock after the accepting `tick`.
- The Enter path follows the same latency. `data_valid` rises on the clock after the debounced edge.
- One key is accepted per press. Holding a key never repeats. A second key pressed while the first is held is ignored until a full release.
- All outputs are registered.

## Structure
- Package `keypad_pkg`:
  - FSM state encoding (SCAN/DEBOUNCE/RELEASE);
  - default `SCAN_DIV` and `DEB_SAMPLES`;
  - the `{row,col}` key-code constants used by the display and CPU test programs.
- Sub-module `btn_debounce` (sync + tick-sampled counter + rising-edge pulse). It is instantiated for Enter and is reusable for the other board buttons.
- Tick generator, scan FSM, entry register and handshake stay in the top module.

## Test plan
All scenarios use `SCAN_DIV=4` and `DEB_SAMPLES=3`.
- **Reset:** assert `rst` mid-run → `col`=1110, `entry`=0, `data_valid`=0 immediately, with no clock needed.
- **Clean press:** hold row1 low while `col_idx`=2 for 5 ticks, then release for 4 ticks → exactly one `key_strobe`, `key_code`=6, `entry`=0x0006.
- **Bounce:** row low 1 tick, high 1 tick, low 1 tick → no strobe. Next stable press of key 0xA → one strobe.
- **Accumulation:** type keys 1,2,3,4,5 → `entry`=0x2345. Press Enter → `data_out`=0x2345, `data_valid`=1, `entry`=0. Hold `data_ready` for 1 cycle → `data_valid`=0 on the next edge.
- **Overwrite:**
  - Enter with 0x00AB → `data_valid`=1.
  - Without consuming, type 0xC and press Enter → `data_out`=0x000C, `data_valid` still 1.
  - Enter edge coincident with `data_ready` → `data_valid` stays 1.
- **Two rows low:** rows 0 and 2 low on col 3 → code 0x3. No further key is accepted until all rows are high for 3 ticks.
